dx_fwd_stage: RTL and testbench

- Parametrised decode-to-execute pipeline register with N-source operand forwarding, load-use and long-latency hazard detection, and a ready/valid handshake on both sides.
- Sits between the decode stage and the execute stage. It replaces the purely combinational D/X forwarding mux with a registered stage that creates its own bubbles and stalls.
- Also exposes a saturating stall-cycle performance counter.

---
 rtl/dx_fwd_stage.sv | 202 ++++++++++++++++++++
 tb/tb_dx_fwd_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dx_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dx_fwd_stage
//  Description : Registered decode-to-execute stage with N-source operand
//                forwarding, load-use / long-latency issue blocking, a
//                ready/valid handshake on both sides and a saturating
//                stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dx_fwd_stage #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int PC_W     = 32,
    parameter int CTRL_W   = 16,
    parameter int NSRC     = 2,
    parameter int LONG_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    // decode side
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic [PC_W-1:0]      d_pc,
    input  logic [CTRL_W-1:0]    d_ctrl,
    input  logic [AW-1:0]        d_rs_addr,
    input  logic [AW-1:0]        d_rt_addr,
    input  logic [AW-1:0]        d_rd_addr,
    input  logic [DW-1:0]        d_rs,
    input  logic [DW-1:0]        d_rt,
    input  logic [DW-1:0]        d_imm,
    input  logic                 d_is_long,
    // forwarding sources, index 0 is the youngest
    input  logic [NSRC-1:0]      fwd_valid,
    input  logic [NSRC-1:0]      fwd_pending,
    input  logic [NSRC*AW-1:0]   fwd_addr,
    input  logic [NSRC*DW-1:0]   fwd_data,
    // execute side
    output logic                 x_valid,
    input  logic                 x_ready,
    output logic [PC_W-1:0]      x_pc,
    output logic [CTRL_W-1:0]    x_ctrl,
    output logic [DW-1:0]        x_rs,
    output logic [DW-1:0]        x_rt,
    output logic [AW-1:0]        x_rs_addr,
    output logic [AW-1:0]        x_rt_addr,
    output logic [AW-1:0]        x_rd_addr,
    output logic [DW-1:0]        x_imm,
    // status
    output logic                 hazard,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int               c_BLK_W    = $clog2(LONG_LAT) + 1;
    localparam logic [c_BLK_W-1:0] c_BLK_INIT = c_BLK_W'(LONG_LAT - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_ONE  = c_BLK_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Per-source address match for each operand (register 0 never matches)
    // ------------------------------------------------------------------
    logic [NSRC-1:0] w_rs_match;
    logic [NSRC-1:0] w_rt_match;
    logic [DW-1:0]   w_src_data [NSRC];

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_rs_match[gi] = fwd_valid[gi]
                                  && (fwd_addr[gi*AW +: AW] == d_rs_addr)
                                  && (d_rs_addr != '0);
            assign w_rt_match[gi] = fwd_valid[gi]
                                  && (fwd_addr[gi*AW +: AW] == d_rt_addr)
                                  && (d_rt_addr != '0);
            assign w_src_data[gi] = fwd_data[gi*DW +: DW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority select: scanning from oldest to youngest lets the youngest
    // (lowest-index) match overwrite, so only its pending bit matters.
    // ------------------------------------------------------------------
    logic [DW-1:0] w_rs_val;
    logic [DW-1:0] w_rt_val;
    logic          w_rs_pend;
    logic          w_rt_pend;

    // Resolve forwarded operand values and their pending status
    always_comb begin
        w_rs_val  = d_rs;
        w_rt_val  = d_rt;
        w_rs_pend = 1'b0;
        w_rt_pend = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_rs_match[i]) begin
                w_rs_val  = w_src_data[i];
                w_rs_pend = fwd_pending[i];
            end
            if (w_rt_match[i]) begin
                w_rt_val  = w_src_data[i];
                w_rt_pend = fwd_pending[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic               r_x_valid;
    logic [c_BLK_W-1:0] r_blk;
    logic               w_advance;
    logic               w_accept;

    assign w_advance = !r_x_valid || x_ready;
    assign hazard    = w_rs_pend || w_rt_pend || (r_blk != '0);
    assign d_ready   = w_advance && !hazard && !flush;
    assign w_accept  = d_valid && d_ready;

    // ------------------------------------------------------------------
    // Pipeline register and issue-block counter
    // ------------------------------------------------------------------
    logic [PC_W-1:0]   r_x_pc;
    logic [CTRL_W-1:0] r_x_ctrl;
    logic [DW-1:0]     r_x_rs;
    logic [DW-1:0]     r_x_rt;
    logic [AW-1:0]     r_x_rs_addr;
    logic [AW-1:0]     r_x_rt_addr;
    logic [AW-1:0]     r_x_rd_addr;
    logic [DW-1:0]     r_x_imm;

    // Stage register: reset > flush > hold > capture > bubble
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_x_valid   <= 1'b0;
            r_x_pc      <= '0;
            r_x_ctrl    <= '0;
            r_x_rs      <= '0;
            r_x_rt      <= '0;
            r_x_rs_addr <= '0;
            r_x_rt_addr <= '0;
            r_x_rd_addr <= '0;
            r_x_imm     <= '0;
            r_blk       <= '0;
        end else if (!w_advance) begin
            // contents hold; only the issue block keeps draining
            if (r_blk != '0) begin
                r_blk <= r_blk - c_BLK_ONE;
            end
        end else if (w_accept) begin
            r_x_valid   <= 1'b1;
            r_x_pc      <= d_pc;
            r_x_ctrl    <= d_ctrl;
            r_x_rs      <= w_rs_val;
            r_x_rt      <= w_rt_val;
            r_x_rs_addr <= d_rs_addr;
            r_x_rt_addr <= d_rt_addr;
            r_x_rd_addr <= d_rd_addr;
            r_x_imm     <= d_imm;
            r_blk       <= d_is_long ? c_BLK_INIT : '0;
        end else begin
            r_x_valid   <= 1'b0;
            r_x_pc      <= '0;
            r_x_ctrl    <= '0;
            r_x_rs      <= '0;
            r_x_rt      <= '0;
            r_x_rs_addr <= '0;
            r_x_rt_addr <= '0;
            r_x_rd_addr <= '0;
            r_x_imm     <= '0;
            if (r_blk != '0) begin
                r_blk <= r_blk - c_BLK_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle counter; a flush cycle is not counted as a stall
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where decode offers but is refused
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!flush && d_valid && !d_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign x_valid   = r_x_valid;
    assign x_pc      = r_x_pc;
    assign x_ctrl    = r_x_ctrl;
    assign x_rs      = r_x_rs;
    assign x_rt      = r_x_rt;
    assign x_rs_addr = r_x_rs_addr;
    assign x_rt_addr = r_x_rt_addr;
    assign x_rd_addr = r_x_rd_addr;
    assign x_imm     = r_x_imm;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dx_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dx_fwd_stage
//  Description : Self-checking bench for dx_fwd_stage. Directed stimulus
//                pushes expected execute-side transactions into a queue; a
//                monitor pops and compares on every x_valid/x_ready transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dx_fwd_stage;

    localparam int DW = 32, AW = 5, PC_W = 32, CTRL_W = 16;
    localparam int NSRC = 2, LONG_LAT = 3, CNT_W = 4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [DW-1:0]     rs;
        logic [DW-1:0]     rt;
        logic [AW-1:0]     rs_addr;
        logic [AW-1:0]     rt_addr;
        logic [AW-1:0]     rd_addr;
        logic [DW-1:0]     imm;
    } xact_t;

    logic clk = 1'b0;
    logic reset, flush;
    logic d_valid, d_ready, d_is_long;
    logic [PC_W-1:0] d_pc;
    logic [CTRL_W-1:0] d_ctrl;
    logic [AW-1:0] d_rs_addr, d_rt_addr, d_rd_addr;
    logic [DW-1:0] d_rs, d_rt, d_imm;
    logic [NSRC-1:0] fwd_valid, fwd_pending;
    logic [NSRC*AW-1:0] fwd_addr;
    logic [NSRC*DW-1:0] fwd_data;
    logic x_valid, x_ready, hazard;
    logic [PC_W-1:0] x_pc;
    logic [CTRL_W-1:0] x_ctrl;
    logic [DW-1:0] x_rs, x_rt, x_imm;
    logic [AW-1:0] x_rs_addr, x_rt_addr, x_rd_addr;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    xact_t exp_q[$];

    dx_fwd_stage #(
        .DW(DW), .AW(AW), .PC_W(PC_W), .CTRL_W(CTRL_W),
        .NSRC(NSRC), .LONG_LAT(LONG_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_ctrl(d_ctrl),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr), .d_rd_addr(d_rd_addr),
        .d_rs(d_rs), .d_rt(d_rt), .d_imm(d_imm), .d_is_long(d_is_long),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_pc(x_pc), .x_ctrl(x_ctrl),
        .x_rs(x_rs), .x_rt(x_rt), .x_rs_addr(x_rs_addr), .x_rt_addr(x_rt_addr),
        .x_rd_addr(x_rd_addr), .x_imm(x_imm),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic xact_t mk(input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                                 input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                                 input logic [AW-1:0] rsa, input logic [AW-1:0] rta,
                                 input logic [AW-1:0] rda, input logic [DW-1:0] imm);
        xact_t t;
        t.pc = pc; t.ctrl = ctrl; t.rs = rs; t.rt = rt;
        t.rs_addr = rsa; t.rt_addr = rta; t.rd_addr = rda; t.imm = imm;
        return t;
    endfunction

    function automatic xact_t x_now();
        return {x_pc, x_ctrl, x_rs, x_rt, x_rs_addr, x_rt_addr, x_rd_addr, x_imm};
    endfunction

    // Scoreboard monitor: every execute-side transfer must match the queue head
    always @(negedge clk) begin
        if (!reset && x_valid && x_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", x_now(), '0);
            end else begin
                chk("xfer", x_now(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_is_long = 1'b0; flush = 1'b0; x_ready = 1'b1;
        d_pc = '0; d_ctrl = '0; d_rs_addr = '0; d_rt_addr = '0; d_rd_addr = '0;
        d_rs = '0; d_rt = '0; d_imm = '0;
        fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
    endtask

    task automatic instr(input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                         input logic [AW-1:0] rsa, input logic [AW-1:0] rta,
                         input logic [AW-1:0] rda, input logic [DW-1:0] rs,
                         input logic [DW-1:0] rt, input logic [DW-1:0] imm,
                         input logic is_long);
        d_valid = 1'b1; d_pc = pc; d_ctrl = ctrl; d_rs_addr = rsa; d_rt_addr = rta;
        d_rd_addr = rda; d_rs = rs; d_rt = rt; d_imm = imm; d_is_long = is_long;
    endtask

    task automatic fwd(input logic [1:0] v, input logic [1:0] p,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                       input logic [DW-1:0] dt1, input logic [DW-1:0] dt0);
        fwd_valid = v; fwd_pending = p; fwd_addr = {a1, a0}; fwd_data = {dt1, dt0};
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // ---------------- reset with arbitrary inputs ----------------
        reset = 1'b1;
        idle();
        instr(32'hDEAD_0000, 16'hFFFF, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 1'b1);
        fwd(2'b11, 2'b11, 5'd3, 5'd4, 32'hAB, 32'hCD);
        x_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        idle();
        d_valid = 1'b1;
        #1;
        chk("rst_x_valid", x_valid, 1'b0);
        chk("rst_x_fields", x_now(), '0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_d_ready", d_ready, 1'b1);
        d_valid = 1'b0;
        step();

        // ---------------- forwarding priority ----------------
        instr(32'h100, 16'h0011, 5'd5, 5'd0, 5'd3, 32'h5555, 32'h7777, 32'h10, 1'b0);
        fwd(2'b11, 2'b00, 5'd5, 5'd5, 32'hBBBB, 32'hAAAA);
        #1;
        chk("fwd_prio_d_ready", d_ready, 1'b1);
        exp_q.push_back(mk(32'h100, 16'h0011, 32'hAAAA, 32'h7777, 5'd5, 5'd0, 5'd3, 32'h10));
        step();
        // src0 addressed to r0: never matches, older src1 supplies rs
        instr(32'h104, 16'h0022, 5'd5, 5'd0, 5'd6, 32'h5555, 32'h7777, 32'h20, 1'b0);
        fwd(2'b11, 2'b00, 5'd5, 5'd0, 32'hBBBB, 32'hCCCC);
        #1;
        chk("fwd_r0_d_ready", d_ready, 1'b1);
        exp_q.push_back(mk(32'h104, 16'h0022, 32'hBBBB, 32'h7777, 5'd5, 5'd0, 5'd6, 32'h20));
        step();
        // pending older source shadowed by a non-pending younger match
        instr(32'h108, 16'h0033, 5'd9, 5'd6, 5'd7, 32'h9999, 32'h6666, 32'h30, 1'b0);
        fwd(2'b11, 2'b10, 5'd6, 5'd6, 32'h1111, 32'h2222);
        #1;
        chk("shadow_hazard", hazard, 1'b0);
        chk("shadow_d_ready", d_ready, 1'b1);
        exp_q.push_back(mk(32'h108, 16'h0033, 32'h9999, 32'h2222, 5'd9, 5'd6, 5'd7, 32'h30));
        step();
        idle();
        step();

        // ---------------- load-use ----------------
        do_reset();
        instr(32'h200, 16'h0044, 5'd7, 5'd2, 5'd8, 32'hDEAD, 32'h0202, 32'h40, 1'b0);
        fwd(2'b01, 2'b01, 5'd0, 5'd7, 32'h0, 32'h0);
        #1;
        chk("ldu_hazard", hazard, 1'b1);
        chk("ldu_d_ready", d_ready, 1'b0);
        step();
        chk("ldu_bubble", x_valid, 1'b0);
        chk("ldu_stall_cnt", stall_cnt, 1);
        fwd(2'b01, 2'b00, 5'd0, 5'd7, 32'h0, 32'h1234);
        #1;
        chk("ldu_release", d_ready, 1'b1);
        exp_q.push_back(mk(32'h200, 16'h0044, 32'h1234, 32'h0202, 5'd7, 5'd2, 5'd8, 32'h40));
        step();
        chk("ldu_x_valid", x_valid, 1'b1);
        idle();
        step();

        // ---------------- long-latency issue block ----------------
        do_reset();
        instr(32'h300, 16'h0055, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h50, 1'b1);
        #1;
        chk("long_accept", d_ready, 1'b1);
        exp_q.push_back(mk(32'h300, 16'h0055, 32'h11, 32'h22, 5'd1, 5'd2, 5'd3, 32'h50));
        step();
        instr(32'h304, 16'h0066, 5'd4, 5'd5, 5'd6, 32'h44, 32'h55, 32'h60, 1'b0);
        #1;
        chk("long_block1", d_ready, 1'b0);
        step();
        chk("long_block2", d_ready, 1'b0);
        step();
        chk("long_free", d_ready, 1'b1);
        chk("long_stall_cnt", stall_cnt, 2);
        exp_q.push_back(mk(32'h304, 16'h0066, 32'h44, 32'h55, 5'd4, 5'd5, 5'd6, 32'h60));
        step();
        idle();
        step();

        // ---------------- backpressure then flush ----------------
        do_reset();
        x_ready = 1'b0;
        instr(32'h400, 16'h0077, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'h70, 1'b0);
        #1;
        chk("bp_accept", d_ready, 1'b1);
        step();
        instr(32'h404, 16'h0088, 5'd4, 5'd5, 5'd6, 32'hB1, 32'hB2, 32'h80, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_hold_valid", x_valid, 1'b1);
            chk("bp_hold_fields", x_now(),
                mk(32'h400, 16'h0077, 32'hA1, 32'hA2, 5'd1, 5'd2, 5'd3, 32'h70));
            chk("bp_d_ready", d_ready, 1'b0);
            step();
        end
        chk("bp_stall_cnt", stall_cnt, 3);
        d_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_d_ready", d_ready, 1'b0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_x_valid", x_valid, 1'b0);
        chk("flush_x_fields", x_now(), '0);
        chk("flush_hazard", hazard, 1'b0);
        chk("flush_stall_cnt", stall_cnt, 3);
        idle();
        step();

        // ---------------- flush clears a live issue block ----------------
        do_reset();
        instr(32'h500, 16'h0099, 5'd1, 5'd2, 5'd3, 32'hC1, 32'hC2, 32'h90, 1'b1);
        step();
        d_valid = 1'b0; d_is_long = 1'b0;
        x_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        x_ready = 1'b1;
        instr(32'h504, 16'h00AA, 5'd4, 5'd5, 5'd6, 32'hD1, 32'hD2, 32'hA0, 1'b0);
        #1;
        chk("flush_blk_clear", d_ready, 1'b1);
        exp_q.push_back(mk(32'h504, 16'h00AA, 32'hD1, 32'hD2, 5'd4, 5'd5, 5'd6, 32'hA0));
        step();
        idle();
        step();

        // ---------------- stall counter saturation ----------------
        do_reset();
        instr(32'h600, 16'h00BB, 5'd7, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0);
        fwd(2'b01, 2'b01, 5'd0, 5'd7, 32'h0, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) chk("sat_cnt14", stall_cnt, 14);
            if (k == 15) chk("sat_cnt15", stall_cnt, 15);
            if (k == 20) chk("sat_cnt20", stall_cnt, 15);
        end
        chk("sat_no_issue", x_valid, 1'b0);
        // reset in the middle of the stall clears the counter
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("midstall_rst_cnt", stall_cnt, 0);
        idle();
        step();

        for (int k = 0; k < 4; k++) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
